// File: rtl/pong_pkg.sv
// Shared constants for the pong collision/score logic.
package pong_pkg;

  localparam int unsigned SCREEN_X = 640;
  localparam int unsigned SCREEN_Y = 480;

  // Bounce codes consumed by the ball FSM
  localparam logic [1:0] BOUNCE_NONE   = 2'b00;
  localparam logic [1:0] BOUNCE_PADDLE = 2'b01;
  localparam logic [1:0] BOUNCE_WALL   = 2'b10;
  localparam logic [1:0] BOUNCE_SCORE  = 2'b11;

  typedef enum logic [1:0] {
    StWatch,
    StHold,
    StScoreHold,
    StGameOver
  } state_e;

endpackage

// File: rtl/score_counter.sv
// Saturating 4-bit score counter; stops counting once it reaches MAX.
module score_counter #(
  parameter int unsigned MAX = 9
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_inc,
  output logic [3:0] o_count,
  output logic       o_at_max
);

  logic [3:0] r_count;

  assign o_at_max = (r_count == 4'(MAX));
  assign o_count  = r_count;

  // Count up on each increment request until saturated
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_inc && !o_at_max) begin
      r_count <= r_count + 4'd1;
    end
  end

endmodule

// File: rtl/ball_collision.sv
// Collision and score arbiter feeding the ball FSM: decodes hits from the
// ball/paddle geometry, issues a held bounce code, tracks speed and scores.
module ball_collision
  import pong_pkg::*;
#(
  parameter int unsigned PADDLE_L_X  = 16,
  parameter int unsigned PADDLE_R_X  = 616,
  parameter int unsigned PADDLE_W    = 8,
  parameter int unsigned PADDLE_H    = 64,
  parameter int unsigned START_SPEED = 7,
  parameter int unsigned MIN_SPEED   = 2,
  parameter int unsigned LOCK_STEPS  = 4,
  parameter int unsigned WIN_SCORE   = 9
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic [9:0] i_ball_x,
  input  logic [9:0] i_ball_y,
  input  logic [7:0] i_ball_w,
  input  logic [7:0] i_ball_h,
  input  logic [9:0] i_paddle_l_y,
  input  logic [9:0] i_paddle_r_y,
  output logic [1:0] o_bounce,
  output logic [2:0] o_speed,
  output logic [3:0] o_score_l,
  output logic [3:0] o_score_r,
  output logic       o_game_over
);

  localparam int unsigned LOCK_W = $clog2(LOCK_STEPS + 1);

  localparam logic [10:0] LP_SCREEN_X = 11'(SCREEN_X);
  localparam logic [10:0] LP_SCREEN_Y = 11'(SCREEN_Y);
  localparam logic [10:0] LP_PL_X     = 11'(PADDLE_L_X);
  localparam logic [10:0] LP_PR_X     = 11'(PADDLE_R_X);
  localparam logic [10:0] LP_PAD_W    = 11'(PADDLE_W);
  localparam logic [10:0] LP_PAD_H    = 11'(PADDLE_H);
  localparam logic [2:0]  LP_START    = 3'(START_SPEED);
  localparam logic [2:0]  LP_MIN      = 3'(MIN_SPEED);
  localparam logic [3:0]  LP_WIN_M1   = 4'(WIN_SCORE - 1);
  localparam logic [LOCK_W-1:0] LP_LOCK = LOCK_W'(LOCK_STEPS);

  state_e            r_state;
  logic [1:0]        r_bounce;
  logic [2:0]        r_speed;
  logic              r_game_over;
  logic [LOCK_W-1:0] r_lock;
  logic [19:0]       r_prev;

  logic [10:0] w_x0, w_x1, w_y0, w_y1, w_pl_y0, w_pr_y0;
  logic        w_step, w_goal_l, w_goal_r, w_goal, w_wall;
  logic        w_pad_l, w_pad_r, w_pad, w_win;
  logic        w_inc_l, w_inc_r, w_max_l, w_max_r;

  // 11-bit geometry so edge sums never wrap
  assign w_x0    = {1'b0, i_ball_x};
  assign w_y0    = {1'b0, i_ball_y};
  assign w_x1    = w_x0 + {3'b000, i_ball_w};
  assign w_y1    = w_y0 + {3'b000, i_ball_h};
  assign w_pl_y0 = {1'b0, i_paddle_l_y};
  assign w_pr_y0 = {1'b0, i_paddle_r_y};

  assign w_step   = (r_prev != {i_ball_x, i_ball_y});
  assign w_goal_r = (w_x0 == 11'd0);
  assign w_goal_l = (w_x1 >= LP_SCREEN_X);
  assign w_goal   = w_goal_l | w_goal_r;
  assign w_wall   = (w_y0 == 11'd0) | (w_y1 >= LP_SCREEN_Y);

  // x test counts face contact (ball touching a paddle edge) as a hit;
  // y test is a strict overlap of the two vertical extents.
  assign w_pad_l = (w_x0 <= LP_PL_X + LP_PAD_W) && (w_x1 >= LP_PL_X) &&
                   (w_y0 < w_pl_y0 + LP_PAD_H) && (w_y1 > w_pl_y0);
  assign w_pad_r = (w_x0 <= LP_PR_X + LP_PAD_W) && (w_x1 >= LP_PR_X) &&
                   (w_y0 < w_pr_y0 + LP_PAD_H) && (w_y1 > w_pr_y0);
  assign w_pad   = (w_pad_l | w_pad_r) & (r_lock == '0);

  // Scoring is only evaluated while watching; right goal wins a tie
  assign w_inc_r = (r_state == StWatch) & w_goal_r & ~w_max_r;
  assign w_inc_l = (r_state == StWatch) & ~w_goal_r & w_goal_l & ~w_max_l;
  assign w_win   = w_goal_r ? (o_score_r == LP_WIN_M1) : (o_score_l == LP_WIN_M1);

  score_counter #(.MAX(WIN_SCORE)) u_score_l (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_inc    (w_inc_l),
    .o_count  (o_score_l),
    .o_at_max (w_max_l)
  );

  score_counter #(.MAX(WIN_SCORE)) u_score_r (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_inc    (w_inc_r),
    .o_count  (o_score_r),
    .o_at_max (w_max_r)
  );

  // Arbiter FSM with registered bounce, speed, lockout and game-over
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= StWatch;
      r_bounce    <= BOUNCE_NONE;
      r_speed     <= LP_START;
      r_game_over <= 1'b0;
      r_lock      <= '0;
      r_prev      <= {i_ball_x, i_ball_y};
    end else begin
      r_prev <= {i_ball_x, i_ball_y};
      // Lockout counts ball steps in every live state; later writes override
      if (r_state != StGameOver && w_step && r_lock != '0) begin
        r_lock <= r_lock - 1'b1;
      end
      unique case (r_state)
        StWatch: begin
          if (w_goal) begin
            r_bounce <= BOUNCE_SCORE;
            r_speed  <= LP_START;
            if (w_win) begin
              r_game_over <= 1'b1;
              r_state     <= StGameOver;
            end else begin
              r_state <= StScoreHold;
            end
          end else if (w_pad) begin
            r_bounce <= BOUNCE_PADDLE;
            r_speed  <= (r_speed > LP_MIN) ? r_speed - 3'd1 : LP_MIN;
            r_lock   <= LP_LOCK;
            r_state  <= StHold;
          end else if (w_wall) begin
            r_bounce <= BOUNCE_WALL;
            r_state  <= StHold;
          end else begin
            r_bounce <= BOUNCE_NONE;
          end
        end
        StHold: begin
          if (w_step) begin
            r_bounce <= BOUNCE_NONE;
            r_state  <= StWatch;
          end
        end
        StScoreHold: begin
          if (w_step) begin
            r_bounce <= BOUNCE_NONE;
            r_lock   <= '0;
            r_state  <= StWatch;
          end
        end
        StGameOver: begin
          r_bounce <= BOUNCE_SCORE;
        end
        default: begin
          r_state <= StWatch;
        end
      endcase
    end
  end

  assign o_bounce    = r_bounce;
  assign o_speed     = r_speed;
  assign o_game_over = r_game_over;

endmodule

// File: tb/tb_ball_collision.sv
// Self-checking bench for ball_collision: directed scenarios plus a random
// phase, all compared against a cycle-level behavioural model of the rules.
module tb_ball_collision;

  localparam int SX = 640, SY = 480;
  localparam int PLX = 16, PRX = 616, PW = 8, PH = 64;
  localparam int START = 7, MINS = 2, LOCKN = 4, WIN = 9;

  logic       clk, rst;
  logic [9:0] ball_x, ball_y, pad_l_y, pad_r_y;
  logic [7:0] ball_w, ball_h;
  logic [1:0] bounce;
  logic [2:0] speed;
  logic [3:0] score_l, score_r;
  logic       game_over;

  int total = 0;
  int bad   = 0;

  // Model state: a non-zero bounce code is held until the ball moves
  int m_bounce, m_speed, m_sl, m_sr, m_lock, m_px, m_py;
  bit m_over;

  ball_collision dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_ball_x     (ball_x),
    .i_ball_y     (ball_y),
    .i_ball_w     (ball_w),
    .i_ball_h     (ball_h),
    .i_paddle_l_y (pad_l_y),
    .i_paddle_r_y (pad_r_y),
    .o_bounce     (bounce),
    .o_speed      (speed),
    .o_score_l    (score_l),
    .o_score_r    (score_r),
    .o_game_over  (game_over)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    total++;
    assert (got === 32'(exp)) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic bit touches(int x0, int x1, int y0, int y1, int px, int py);
    return (x0 <= px + PW) && (x1 >= px) && (y0 < py + PH) && (y1 > py);
  endfunction

  task automatic model_reset();
    m_bounce = 0; m_speed = START; m_sl = 0; m_sr = 0; m_lock = 0; m_over = 0;
    m_px = int'(ball_x); m_py = int'(ball_y);
  endtask

  // Advance the model by one clock using the inputs present at the edge
  task automatic model_clock();
    int  x0, x1, y0, y1, nlock;
    bit  step, gl, gr, wall, pad;
    x0 = int'(ball_x); y0 = int'(ball_y);
    x1 = x0 + int'(ball_w); y1 = y0 + int'(ball_h);
    step = (x0 != m_px) || (y0 != m_py);
    m_px = x0; m_py = y0;
    if (m_over) return;
    nlock = (step && m_lock > 0) ? m_lock - 1 : m_lock;
    if (m_bounce != 0) begin
      if (step) begin
        if (m_bounce == 3) nlock = 0;
        m_bounce = 0;
      end
    end else begin
      gr   = (x0 == 0);
      gl   = (x1 >= SX);
      wall = (y0 == 0) || (y1 >= SY);
      pad  = (touches(x0, x1, y0, y1, PLX, int'(pad_l_y)) ||
              touches(x0, x1, y0, y1, PRX, int'(pad_r_y))) && (m_lock == 0);
      if (gr || gl) begin
        if (gr) begin
          if (m_sr < WIN) m_sr++;
          if (m_sr == WIN) m_over = 1;
        end else begin
          if (m_sl < WIN) m_sl++;
          if (m_sl == WIN) m_over = 1;
        end
        m_speed  = START;
        m_bounce = 3;
      end else if (pad) begin
        m_bounce = 1;
        m_speed  = (m_speed - 1 < MINS) ? MINS : m_speed - 1;
        nlock    = LOCKN;
      end else if (wall) begin
        m_bounce = 2;
      end
    end
    m_lock = nlock;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".bounce"}, 32'(bounce), m_bounce);
    chk({tag, ".speed"}, 32'(speed), m_speed);
    chk({tag, ".score_l"}, 32'(score_l), m_sl);
    chk({tag, ".score_r"}, 32'(score_r), m_sr);
    chk({tag, ".game_over"}, 32'(game_over), int'(m_over));
  endtask

  task automatic cycle(input string tag);
    model_clock();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic move(input int x, input int y, input string tag);
    ball_x = 10'(x);
    ball_y = 10'(y);
    cycle(tag);
  endtask

  // Async reset asserted mid-cycle and released before the next edge
  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    check_model(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int last_hit, hits, xv, yv;
    rst = 1'b1;
    ball_x = 10'd320; ball_y = 10'd240; ball_w = 8'd8; ball_h = 8'd8;
    pad_l_y = 10'd180; pad_r_y = 10'd100;
    #1;
    model_reset();
    check_model("reset");
    @(negedge clk);
    rst = 1'b0;

    // Bottom wall: held until the next step, then cleared
    move(320, 470, "t1a");
    move(320, 472, "t1b");
    chk("t1_wall", 32'(bounce), 2);
    cycle("t1c");
    chk("t1_wall_held", 32'(bounce), 2);
    move(320, 471, "t1d");
    chk("t1_clear", 32'(bounce), 0);

    // Left player goal
    move(632, 240, "t4a");
    chk("t4_bounce", 32'(bounce), 3);
    chk("t4_score_l", 32'(score_l), 1);
    chk("t4_speed", 32'(speed), 7);
    cycle("t4b");
    move(321, 241, "t4c");
    chk("t4_clear", 32'(bounce), 0);

    // Paddle hits with lockout; speed floors at MIN
    move(24, 200, "t2a");
    chk("t2_bounce", 32'(bounce), 1);
    chk("t2_speed", 32'(speed), 6);
    last_hit = 0;
    hits = 0;
    for (int i = 1; i <= 40; i++) begin
      move(24, (i % 2 == 1) ? 201 : 200, "t3");
      if (bounce == 2'b01) begin
        chk("t3_lock_gap", 32'(i - last_hit), LOCKN + 1);
        last_hit = i;
        hits++;
      end
    end
    chk("t3_hits", 32'(hits), 8);
    chk("t2_speed_floor", 32'(speed), MINS);

    // Reset while a wall bounce is being held
    move(320, 0, "t6a");
    cycle("t6b");
    chk("t6_wall", 32'(bounce), 2);
    cycle("t6c");
    pulse_reset("t6rst");
    chk("t6_bounce", 32'(bounce), 0);
    chk("t6_score_l", 32'(score_l), 0);
    chk("t6_speed", 32'(speed), 7);
    cycle("t6d");
    move(320, 240, "t6e");

    // Right player reaches the winning score; further goals are ignored
    for (int g = 0; g < 9; g++) begin
      move(0, 240, "t5goal");
      move(320, 240, "t5serve");
    end
    chk("t5_score_r", 32'(score_r), 9);
    chk("t5_over", 32'(game_over), 1);
    chk("t5_bounce", 32'(bounce), 3);
    for (int g = 0; g < 3; g++) begin
      move(0, 240, "t5more");
      move(320, 240, "t5more2");
    end
    chk("t5_score_sat", 32'(score_r), 9);
    chk("t5_bounce_held", 32'(bounce), 3);

    // Random phase biased toward edges, paddles and holds
    pulse_reset("rnd_rst");
    for (int n = 0; n < 3000; n++) begin
      if (n % 600 == 599) pulse_reset("rnd_rst");
      if ($urandom_range(0, 49) == 0) begin
        ball_w  = 8'($urandom_range(1, 16));
        ball_h  = 8'($urandom_range(1, 16));
        pad_l_y = 10'($urandom_range(0, 420));
        pad_r_y = 10'($urandom_range(0, 420));
      end
      if ($urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 5))
          0:       xv = 0;
          1:       xv = SX - int'(ball_w) - 1 + int'($urandom_range(0, 2));
          2:       xv = int'($urandom_range(8, 30));
          3:       xv = int'($urandom_range(600, 630));
          default: xv = int'($urandom_range(1, 620));
        endcase
        case ($urandom_range(0, 4))
          0:       yv = 0;
          1:       yv = SY - int'(ball_h) - 1 + int'($urandom_range(0, 2));
          2:       yv = int'(pad_l_y) + int'($urandom_range(0, 70)) - 8;
          default: yv = int'($urandom_range(1, 460));
        endcase
        if (yv < 0) yv = 0;
        ball_x = 10'(xv);
        ball_y = 10'(yv);
      end
      cycle("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
